// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared definitions for the LFSR sequencer: FSM state encoding and the
// 74x194-style register mode-select constants {S1,S0}.
package lfsr_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // 2'b10 (shift left on a 194) is never driven by this block
  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_SHIFT = 2'b01;
  localparam logic [1:0] SR_LOAD  = 2'b11;

endpackage

// File: rtl/lfsr_sig_acc.sv
// Signature accumulator: rotate-left-and-XOR compaction of each step value.
// The output is bypassed combinationally during a step cycle so the final
// signature is already visible in the DONE cycle (the last step coincides
// with DONE), and is then held by the register until the next clear.
module lfsr_sig_acc
  import lfsr_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_nx;

  assign sig_nx = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ q;
  assign sig    = en ? sig_nx : sig_q;

  // signature register: cleared on load, folds in Q on every step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else if (clr) begin
      sig_q <= '0;
    end else if (en) begin
      sig_q <= sig_nx;
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// LFSR pattern sequencer for a 74x194-style universal shift register.
// Loads a captured seed, then issues the requested number of shift steps
// with pause support; the LFSR feedback itself lives outside this block.
// Optional: define LFSR_SEQ_SIG_EN to add the SIG signature output.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for START; register held
// ST_LOAD  | one cycle, parallel-load captured seed into register
// ST_RUN   | shifting one step per cycle until count reaches NSTEPS
// ST_PAUSE | HOLD_REQ active; register held, counter frozen
// ST_DONE  | one-cycle completion pulse, counter cleared
module lfsr_seq_ctrl
  import lfsr_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] SEED,
  input  logic [CNT_W-1:0] NSTEPS,
  input  logic             HOLD_REQ,
  input  logic [WIDTH-1:0] Q,
  output logic             S1,
  output logic             S0,
  output logic [WIDTH-1:0] PAR_D,
  output logic             BUSY,
  output logic             STEP_VALID,
`ifdef LFSR_SEQ_SIG_EN
  output logic [WIDTH-1:0] SIG,
`endif
  output logic             DONE
);

  state_t           state_q;
  state_t           state_nx;
  logic [WIDTH-1:0] seed_q;
  logic [CNT_W-1:0] nsteps_q;
  logic [CNT_W-1:0] count_q;
  logic             step_valid_q;
  logic [1:0]       mode;
  logic             capture;
  logic             shift_en;
  logic             last_step;

  // equality compare against the captured count; count never exceeds it
  assign last_step = (count_q + CNT_W'(1)) == nsteps_q;

  // state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // next-state and mode decode; RUN and PAUSE share the resume/hold logic
  // so a PAUSE cycle with HOLD_REQ low already shifts
  always_comb begin
    state_nx = state_q;
    mode     = SR_HOLD;
    capture  = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          capture  = 1'b1;
          state_nx = ST_LOAD;
        end
      end
      ST_LOAD: begin
        mode     = SR_LOAD;
        state_nx = (nsteps_q == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN, ST_PAUSE: begin
        if (HOLD_REQ) begin
          state_nx = ST_PAUSE;
        end else begin
          mode     = SR_SHIFT;
          shift_en = 1'b1;
          state_nx = last_step ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // run parameters captured on START accept, stable for the whole run
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      seed_q   <= '0;
      nsteps_q <= '0;
    end else if (capture) begin
      seed_q   <= SEED;
      nsteps_q <= NSTEPS;
    end
  end

  // step counter: cleared around each run, advanced on every shift
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
    end else if (state_q == ST_LOAD || state_q == ST_DONE) begin
      count_q <= '0;
    end else if (shift_en) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // step-valid follows each shift edge, aligned with the updated Q
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      step_valid_q <= 1'b0;
    end else begin
      step_valid_q <= shift_en;
    end
  end

  assign S1         = mode[1];
  assign S0         = mode[0];
  assign PAR_D      = (state_q == ST_LOAD) ? seed_q : '0;
  assign BUSY       = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign DONE       = (state_q == ST_DONE);
  assign STEP_VALID = step_valid_q;

`ifdef LFSR_SEQ_SIG_EN
  lfsr_sig_acc #(
    .WIDTH (WIDTH)
  ) u_sig_acc (
    .clk (CLK),
    .rst (RESET),
    .clr (state_q == ST_LOAD),
    .en  (step_valid_q),
    .q   (Q),
    .sig (SIG)
  );
`else
  // Q only feeds the signature accumulator
  logic unused_q;
  assign unused_q = ^Q;
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl with a behavioural 194-style register closing
// the loop (serial input = Q[1]^Q[0]). Expected step values are pushed to a
// queue at START and popped on every STEP_VALID.
// Define LFSR_SEQ_SIG_EN to also check the SIG output.
module tb_lfsr_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [2:0] SEED;
  logic [7:0] NSTEPS;
  logic       HOLD_REQ;
  logic [2:0] Q;
  logic       S1, S0;
  logic [2:0] PAR_D;
  logic       BUSY, STEP_VALID, DONE;
`ifdef LFSR_SEQ_SIG_EN
  logic [2:0] SIG;
  logic [2:0] exp_sig = '0;
`endif

  int n_vec = 0;
  int n_mis = 0;
  logic [2:0] exp_q[$];
  logic [2:0] q_reg = '0;

  always #5 CLK = ~CLK;

  lfsr_seq_ctrl #(.WIDTH(3), .CNT_W(8)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .SEED       (SEED),
    .NSTEPS     (NSTEPS),
    .HOLD_REQ   (HOLD_REQ),
    .Q          (Q),
    .S1         (S1),
    .S0         (S0),
    .PAR_D      (PAR_D),
    .BUSY       (BUSY),
    .STEP_VALID (STEP_VALID),
`ifdef LFSR_SEQ_SIG_EN
    .SIG        (SIG),
`endif
    .DONE       (DONE)
  );

  // behavioural 74x194 used as a 3-bit LFSR
  always @(posedge CLK) begin
    case ({S1, S0})
      2'b11:   q_reg <= PAR_D;
      2'b01:   q_reg <= {q_reg[1:0], q_reg[1] ^ q_reg[0]};
      2'b10:   q_reg <= q_reg;
      default: q_reg <= q_reg;
    endcase
  end
  assign Q = q_reg;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] lfsr_nx(input logic [2:0] v);
    return {v[1:0], v[1] ^ v[0]};
  endfunction

  // scoreboard consumer
  always @(negedge CLK) begin
    if (STEP_VALID && !RESET) begin
      if (exp_q.size() == 0) begin
        chk("sv_extra", 1, 0);
      end else begin
        chk("step_q", int'(Q), int'(exp_q.pop_front()));
      end
    end
  end

  // one run: h = shifts before HOLD_REQ goes high, l = hold length in cycles,
  // bs = also drive START mid-run and in the DONE cycle
  task automatic run(input logic [2:0] seed, input int n, input int h,
                     input int l, input bit bs);
    logic [2:0] m;
    logic [1:0] em;
    int done_k;
    int pulses;
    bit hw;
    m = seed;
`ifdef LFSR_SEQ_SIG_EN
    exp_sig = '0;
`endif
    for (int i = 0; i < n; i++) begin
      m = lfsr_nx(m);
      exp_q.push_back(m);
`ifdef LFSR_SEQ_SIG_EN
      exp_sig = {exp_sig[1:0], exp_sig[2]} ^ m;
`endif
    end
    done_k = 2 + n + l;
    SEED   = seed;
    NSTEPS = 8'(n);
    START  = 1'b1;
    @(posedge CLK); #1;
    pulses = 0;
    for (int k = 1; k <= done_k; k++) begin
      hw       = (l > 0) && (k >= 2 + h) && (k <= 1 + h + l);
      HOLD_REQ = hw;
      SEED     = ~seed;
      NSTEPS   = 8'(n + 5);
      START    = bs && (k == 3 || k == done_k);
      @(negedge CLK);
      if (k == 1) em = 2'b11;
      else if (k == done_k) em = 2'b00;
      else em = hw ? 2'b00 : 2'b01;
      chk("mode", int'({S1, S0}), int'(em));
      chk("busy", int'(BUSY), int'(k < done_k));
      chk("done", int'(DONE), int'(k == done_k));
      if (k == 1) chk("par_d", int'(PAR_D), int'(seed));
      if (k == 2) chk("q_seed", int'(Q), int'(seed));
      if (STEP_VALID) pulses++;
`ifdef LFSR_SEQ_SIG_EN
      if (k == done_k) chk("sig_done", int'(SIG), int'(exp_sig));
`endif
      @(posedge CLK); #1;
    end
    START    = 1'b0;
    HOLD_REQ = 1'b0;
    chk("pulses", pulses, n);
    chk("sb_empty", exp_q.size(), 0);
    for (int j = 0; j < 3; j++) begin
      @(negedge CLK);
      chk("idle_busy", int'(BUSY), 0);
      chk("idle_mode", int'({S1, S0}), 0);
      chk("idle_sv", int'(STEP_VALID), 0);
`ifdef LFSR_SEQ_SIG_EN
      chk("sig_hold", int'(SIG), int'(exp_sig));
`endif
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    RESET    = 1'b1;
    START    = 1'b0;
    SEED     = '0;
    NSTEPS   = '0;
    HOLD_REQ = 1'b0;
    #3;
    chk("rst_mode", int'({S1, S0}), 0);
    chk("rst_par_d", int'(PAR_D), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_sv", int'(STEP_VALID), 0);
    chk("rst_done", int'(DONE), 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;

    run(3'b100, 3, 0, 0, 1'b0);
    run(3'b101, 0, 0, 0, 1'b0);
    run(3'b110, 4, 2, 3, 1'b0);
    run(3'b011, 4, 0, 0, 1'b1);

    // abort mid-run after the second shift of five
    m_abort();

    run(3'b111, 255, 0, 0, 1'b0);
    run(3'b001, 7, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  task automatic m_abort();
    logic [2:0] m;
    m = 3'b010;
    for (int i = 0; i < 5; i++) begin
      m = lfsr_nx(m);
      exp_q.push_back(m);
    end
    SEED   = 3'b010;
    NSTEPS = 8'd5;
    START  = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(posedge CLK); #1;
    end
    #1;
    RESET = 1'b1;
    #1;
    chk("abort_mode", int'({S1, S0}), 0);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_done", int'(DONE), 0);
    chk("abort_sv", int'(STEP_VALID), 0);
    exp_q.delete();
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      chk("post_abort_done", int'(DONE), 0);
      chk("post_abort_busy", int'(BUSY), 0);
      @(posedge CLK); #1;
    end
    run(3'b011, 5, 0, 0, 1'b0);
  endtask

endmodule
